// File: rtl/alu_rr_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rr_sequencer
//
// Purpose:
//   Shares one pipelined 32-bit ALU between NREQ requesters. A round-robin
//   arbiter picks at most one request per clock. The sequencer then drives the
//   ALU's skewed inputs: the operands are presented one edge before the opcode.
//   Each result comes back tagged with the id and opcode of the requester that
//   owns it.
//
// Handshake:
//   A request from requester i is accepted at a rising edge where both
//   req_valid[i] and req_ready[i] are high. req_ready is combinational, is
//   one-hot or zero, and may depend on req_valid. It is forced to zero while
//   hold or rst is high. The response side has no backpressure: rsp_valid is a
//   single-cycle pulse, issued exactly three edges after the accept.
//
// Ports:
//   clk, rst              rising-edge clock; synchronous active-high reset
//   req_valid / req_ready per-requester request handshake
//   req_a, req_b, req_op  packed per-requester operands and opcode (slice i)
//   hold                  blocks new grants; ops already in flight complete
//   alu_a, alu_b, alu_op  registered ALU inputs (op lags a/b by one cycle)
//   alu_r                 ALU result
//   rsp_valid, rsp_id,
//   rsp_op, rsp_data      tagged result
//   busy                  at least one op is in flight
// -----------------------------------------------------------------------------
module alu_rr_sequencer #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_op,
    input  logic                 hold,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [2:0]           alu_op,
    input  logic [DW-1:0]        alu_r,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [2:0]           rsp_op,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy
);

    // One extra bit so that ptr + offset does not overflow before the modulo
    // correction.
    localparam int SW = IDW + 1;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic [2:0]     op;
    } tag_t;

    // Priority pointer and pipeline registers.
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [DW-1:0]  alu_a_q, alu_b_q;
    logic [2:0]     alu_op_q;
    tag_t           tag1_q, tag1_d, tag2_q, tag3_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [2:0]     rsp_op_q;
    logic [DW-1:0]  rsp_data_q;

    // Unpacked views of the request buses.
    logic [DW-1:0]  a_arr  [NREQ];
    logic [DW-1:0]  b_arr  [NREQ];
    logic [2:0]     op_arr [NREQ];

    // Arbitration.
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [SW-1:0]  scan_sum;
    logic [IDW-1:0] scan_id;
    logic           accept;

    always_comb begin : unpack_requests
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = req_a[i*DW +: DW];
            b_arr[i]  = req_b[i*DW +: DW];
            op_arr[i] = req_op[i*3 +: 3];
        end
    end

    // Round-robin scan: offset k = 0 is the pointer itself, so the requester
    // at the pointer has the highest priority. The first valid requester found
    // while scanning upward (modulo NREQ) wins.
    always_comb begin : round_robin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_sum  = '0;
        scan_id   = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + SW'(k);
            if (scan_sum >= SW'(NREQ)) begin
                scan_sum = scan_sum - SW'(NREQ);
            end
            scan_id = scan_sum[IDW-1:0];
            if (!gnt_found && req_valid[scan_id]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_id;
            end
        end
        if (gnt_found && !hold && !rst) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign accept = gnt_found & ~hold & ~rst;

    // Next pointer and stage-1 tag. A bubble clears only the valid bit. The
    // old id/op are kept, so alu_op does not toggle for idle cycles.
    always_comb begin : next_state
        ptr_d        = ptr_q;
        tag1_d       = tag1_q;
        tag1_d.valid = 1'b0;
        if (accept) begin
            ptr_d        = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
            tag1_d.valid = 1'b1;
            tag1_d.id    = gnt_id;
            tag1_d.op    = op_arr[gnt_id];
        end
    end

    // Pipeline timing for an accept at edge T:
    //   T   : operands to alu_a/alu_b, tag1 loaded
    //   T+1 : ALU samples a/b; alu_op <= tag1.op, tag2 <= tag1
    //   T+2 : ALU samples op and produces r; tag3 <= tag2
    //   T+3 : r captured into rsp_data, with tag3 as id/op/valid
    // All stages advance every cycle; nothing stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            tag3_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            // Operands hold their value through bubbles.
            if (accept) begin
                alu_a_q <= a_arr[gnt_id];
                alu_b_q <= b_arr[gnt_id];
            end
            tag1_q      <= tag1_d;
            alu_op_q    <= tag1_q.op;
            tag2_q      <= tag1_q;
            tag3_q      <= tag2_q;
            rsp_valid_q <= tag3_q.valid;
            // Results of bubbles are discarded; the response fields keep the
            // last real result.
            if (tag3_q.valid) begin
                rsp_id_q   <= tag3_q.id;
                rsp_op_q   <= tag3_q.op;
                rsp_data_q <= alu_r;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = tag1_q.valid | tag2_q.valid | tag3_q.valid;

endmodule
